// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end driven by branch resolution (PcSel/BrPC).
// Holds the fetch PC, issues in-order requests to instruction memory, buffers returned
// words in a 2-entry queue and hands them to decode over a valid/ready handshake. A taken
// redirect reloads the PC, flushes the queue and discards responses still in flight.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   PcSel, BrPC           redirect taken / redirect target (low 2 bits forced to 0)
//   imem_req, imem_addr   fetch request and byte address (the current fetch PC)
//   imem_gnt              request accepted this cycle
//   imem_rvalid, imem_rdata  in-order response
//   if_valid, if_pc, if_instr, if_ready  queue head presented to decode
//   Flush                 IF/ID flush, equal to PcSel outside reset
module fetch_redirect_unit #(
   parameter int unsigned     PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [PC_W-1:0] if_pc,
   output logic [31:0]     if_instr,
   input  logic            if_ready,
   output logic            Flush
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   // Architectural fetch PC
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

   // Instruction queue: two entries addressed by a head pointer and occupancy
   logic [PC_W-1:0] q_pc_q    [2];
   logic [PC_W-1:0] q_pc_d    [2];
   logic [31:0]     q_instr_q [2];
   logic [31:0]     q_instr_d [2];
   logic            q_head_q, q_head_d;
   logic [1:0]      occ_q, occ_d;

   // PCs of granted requests awaiting their response, in request order
   logic [PC_W-1:0] pend_pc_q [2];
   logic [PC_W-1:0] pend_pc_d [2];
   logic            pend_head_q, pend_head_d;
   logic [1:0]      out_q, out_d;

   // Responses still to be thrown away after a redirect
   logic [1:0]      drop_q, drop_d;

   logic            grant;
   logic            resp;
   logic            head_pop;
   logic            pop;
   logic            q_write;
   logic [2:0]      in_use;
   logic            pend_wr_idx;
   logic            q_tail_idx;
   logic [PC_W-1:0] redirect_pc;
   logic            unused_brpc;

   assign redirect_pc = {BrPC[PC_W-1:2], 2'b00};
   assign unused_brpc = ^{BrPC[1:0], BrPC >> PC_W};

   always_comb begin
      // A head pop this cycle frees a slot before any new response can land, which is
      // what sustains one instruction per cycle without ever overfilling the queue.
      head_pop = if_valid && if_ready;
      in_use   = 3'(occ_q) + 3'(out_q) - 3'(head_pop);
      imem_req = !reset && !PcSel && (in_use < 3'd2);
      grant    = imem_req && imem_gnt;
      resp     = imem_rvalid && (out_q != 2'd0);
      pop      = head_pop && !PcSel;
      q_write  = resp && (drop_q == 2'd0) && !PcSel;
      // Writes only happen with at most one entry present, so head+count picks the tail
      pend_wr_idx = pend_head_q ^ out_q[0];
      q_tail_idx  = q_head_q ^ occ_q[0];
   end

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      q_pc_d      = q_pc_q;
      q_instr_d   = q_instr_q;
      q_head_d    = q_head_q;
      occ_d       = occ_q;
      pend_pc_d   = pend_pc_q;
      pend_head_d = pend_head_q;
      out_d       = out_q + {1'b0, grant} - {1'b0, resp};
      drop_d      = drop_q;

      if (grant) begin
         pend_pc_d[pend_wr_idx] = fetch_pc_q;
         fetch_pc_d             = fetch_pc_q + PC_STEP;
      end
      if (resp) begin
         pend_head_d = ~pend_head_q;
      end

      if (PcSel) begin
         fetch_pc_d = redirect_pc;
         occ_d      = 2'd0;
         // Everything still in flight after this cycle's response is stale
         drop_d     = out_q - {1'b0, resp};
      end else begin
         if (resp && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
         end
         if (q_write) begin
            q_pc_d[q_tail_idx]    = pend_pc_q[pend_head_q];
            q_instr_d[q_tail_idx] = imem_rdata;
         end
         if (pop) begin
            q_head_d = ~q_head_q;
         end
         occ_d = occ_q + {1'b0, q_write} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         q_pc_q[0]    <= '0;
         q_pc_q[1]    <= '0;
         q_instr_q[0] <= '0;
         q_instr_q[1] <= '0;
         q_head_q     <= 1'b0;
         occ_q        <= 2'd0;
         pend_pc_q[0] <= '0;
         pend_pc_q[1] <= '0;
         pend_head_q  <= 1'b0;
         out_q        <= 2'd0;
         drop_q       <= 2'd0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         q_pc_q[0]    <= q_pc_d[0];
         q_pc_q[1]    <= q_pc_d[1];
         q_instr_q[0] <= q_instr_d[0];
         q_instr_q[1] <= q_instr_d[1];
         q_head_q     <= q_head_d;
         occ_q        <= occ_d;
         pend_pc_q[0] <= pend_pc_d[0];
         pend_pc_q[1] <= pend_pc_d[1];
         pend_head_q  <= pend_head_d;
         out_q        <= out_d;
         drop_q       <= drop_d;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign if_valid  = (occ_q != 2'd0);
   assign if_pc     = q_pc_q[q_head_q];
   assign if_instr  = q_instr_q[q_head_q];
   assign Flush     = PcSel && !reset;

endmodule
